fetch_execute_control: RTL

FETCH_EXECUTE_CONTROL -- requirements
Module: fetch_execute_control

---
 rtl/fetch_execute_control_pkg.sv | 45 ++++
 rtl/fetch_execute_control_instr_decode.sv | 27 ++
 rtl/fetch_execute_control.sv | 128 ++++++++++++
 3 files changed

// File: rtl/fetch_execute_control_pkg.sv
// Shared definitions for the accumulator-machine fetch/execute controller:
// opcodes, FSM states, instruction classes and SKIPCOND condition codes.
package fetch_execute_control_pkg;

   localparam logic [3:0] OP_LOAD     = 4'h1;
   localparam logic [3:0] OP_STORE    = 4'h2;
   localparam logic [3:0] OP_ADD      = 4'h3;
   localparam logic [3:0] OP_SUBT     = 4'h4;
   localparam logic [3:0] OP_HALT     = 4'h7;
   localparam logic [3:0] OP_SKIPCOND = 4'h8;
   localparam logic [3:0] OP_JUMP     = 4'h9;
   localparam logic [3:0] OP_CLEAR    = 4'hA;

   localparam logic [1:0] SKIP_NEG   = 2'b00;
   localparam logic [1:0] SKIP_ZERO  = 2'b01;
   localparam logic [1:0] SKIP_POS   = 2'b10;
   localparam logic [1:0] SKIP_NEVER = 2'b11;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;

   typedef enum logic [3:0] {
      ST_IDLE   = 4'd0,
      ST_FETCH0 = 4'd1,
      ST_FETCH1 = 4'd2,
      ST_DECODE = 4'd3,
      ST_READ0  = 4'd4,
      ST_READ1  = 4'd5,
      ST_EXEC   = 4'd6,
      ST_WRITE  = 4'd7,
      ST_HALTED = 4'd8
   } state_t;

   typedef enum logic [2:0] {
      CLS_LOAD  = 3'd0,
      CLS_STORE = 3'd1,
      CLS_ADD   = 3'd2,
      CLS_SUBT  = 3'd3,
      CLS_HALT  = 3'd4,
      CLS_SKIP  = 3'd5,
      CLS_JUMP  = 3'd6,
      CLS_CLEAR = 3'd7
   } instr_class_t;

endpackage

// File: rtl/fetch_execute_control_instr_decode.sv
// Combinational opcode decoder: maps IR[15:12] to an instruction class and
// flags opcodes outside the instruction set.
module fetch_execute_control_instr_decode
   import fetch_execute_control_pkg::*;
(
   input  logic [3:0] opcode,
   output logic [2:0] cls,
   output logic       illegal
);

   always_comb begin
      cls     = CLS_HALT;
      illegal = 1'b0;
      case (opcode)
         OP_LOAD:     cls = CLS_LOAD;
         OP_STORE:    cls = CLS_STORE;
         OP_ADD:      cls = CLS_ADD;
         OP_SUBT:     cls = CLS_SUBT;
         OP_HALT:     cls = CLS_HALT;
         OP_SKIPCOND: cls = CLS_SKIP;
         OP_JUMP:     cls = CLS_JUMP;
         OP_CLEAR:    cls = CLS_CLEAR;
         default:     illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/fetch_execute_control.sv
// Multi-cycle fetch/decode/execute controller for a 12-bit-address accumulator
// machine with registered main memory and an external combinational ALU.
module fetch_execute_control
   import fetch_execute_control_pkg::*;
#(
   parameter logic [11:0] RESET_PC = 12'h000
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   output logic        mem_write_enable,
   input  logic [15:0] mem_rdata,
   output logic [3:0]  alu_opcode,
   output logic [15:0] alu_operand1,
   output logic [15:0] alu_operand2,
   input  logic [15:0] alu_result,
   output logic [11:0] pc,
   output logic [15:0] ac,
   output logic [15:0] ir,
   output logic [3:0]  state,
   output logic        halted,
   output logic        illegal_op,
   output logic        instr_retired
);

   state_t             st;
   logic [11:0]        mar;
   logic [15:0]        mbr;
   logic [2:0]         cls;
   logic               illegal;
   logic [11:0]        pc_inc;
   logic signed [15:0] ac_s;
   logic               skip;
   logic               short_instr;

   fetch_execute_control_instr_decode u_decode (
      .opcode  (ir[15:12]),
      .cls     (cls),
      .illegal (illegal)
   );

   assign pc_inc       = pc + 12'd1;
   assign ac_s         = ac;
   assign state        = st;
   assign halted       = (st == ST_HALTED);
   assign mem_write_enable = (st == ST_WRITE);
   assign mem_addr     = {4'b0000, ((st == ST_WRITE) || (st == ST_READ0)) ? mar : pc};
   assign mem_wdata    = ac;
   assign alu_opcode   = (cls == CLS_SUBT) ? ALU_SUB : ALU_ADD;
   assign alu_operand1 = ac;
   assign alu_operand2 = mbr;

   // Instructions that finish in DECODE retire there; illegal opcodes never retire.
   assign short_instr   = (cls == CLS_HALT) || (cls == CLS_SKIP) ||
                          (cls == CLS_JUMP) || (cls == CLS_CLEAR);
   assign instr_retired = (st == ST_EXEC) || (st == ST_WRITE) ||
                          ((st == ST_DECODE) && !illegal && short_instr);

   always_comb begin
      skip = 1'b0;
      case (ir[11:10])
         SKIP_NEG:  skip = (ac_s < 16'sd0);
         SKIP_ZERO: skip = (ac_s == 16'sd0);
         SKIP_POS:  skip = (ac_s > 16'sd0);
         default:   skip = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st         <= ST_IDLE;
         pc         <= RESET_PC;
         ac         <= '0;
         ir         <= '0;
         mar        <= '0;
         mbr        <= '0;
         illegal_op <= 1'b0;
      end else begin
         case (st)
            ST_IDLE:   if (start) st <= ST_FETCH0;
            ST_FETCH0: st <= ST_FETCH1;
            ST_FETCH1: begin
               ir <= mem_rdata;
               pc <= pc_inc;
               st <= ST_DECODE;
            end
            ST_DECODE: begin
               mar <= ir[11:0];
               st  <= ST_FETCH0;
               if (illegal) begin
                  illegal_op <= 1'b1;
                  st         <= ST_HALTED;
               end else begin
                  case (cls)
                     CLS_LOAD, CLS_ADD, CLS_SUBT: st <= ST_READ0;
                     CLS_STORE: st <= ST_WRITE;
                     CLS_JUMP:  pc <= ir[11:0];
                     CLS_CLEAR: ac <= '0;
                     CLS_SKIP:  if (skip) pc <= pc_inc;
                     default:   st <= ST_HALTED;
                  endcase
               end
            end
            ST_READ0: st <= ST_READ1;
            ST_READ1: begin
               mbr <= mem_rdata;
               st  <= ST_EXEC;
            end
            ST_EXEC: begin
               ac <= (cls == CLS_LOAD) ? mbr : alu_result;
               st <= ST_FETCH0;
            end
            ST_WRITE: st <= ST_FETCH0;
            ST_HALTED: begin
               if (start) begin
                  illegal_op <= 1'b0;
                  st         <= ST_FETCH0;
               end
            end
            default: st <= ST_IDLE;
         endcase
      end
   end

endmodule
